// File: rtl/stopwatch_core.sv
// stopwatch_core -- BCD mm:ss stopwatch with pause and per-field adjust.
//
// Counts on tick_1hz, adjusts the selected field and toggles the blink
// qualifier on tick_2hz, and toggles pause on pause_btn. All outputs are
// registered and update on the clk_100mhz edge where their cause is sampled.
//
// Parameters:
//   MAX_MIN      highest minutes value before wrapping to 00 (1..99)
//
// Ports:
//   clk_100mhz   in   system clock
//   rst          in   synchronous active-high reset
//   tick_1hz     in   count enable, one event per high cycle
//   tick_2hz     in   adjust/blink enable, one event per high cycle
//   pause_btn    in   debounced single-cycle pulse, toggles pause
//   adj          in   level, 1 = adjust mode
//   sel          in   level, 0 = adjust minutes, 1 = adjust seconds
//   min_tens, min_ones, sec_tens, sec_ones  out  BCD digits
//   paused       out  pause flag
//   blink_on     out  0 = blank the digits of the selected field
//   rollover     out  one-cycle pulse on the RUN wrap MAX_MIN:59 -> 00:00
//
// Optional feature: define STOPWATCH_ROLLOVER_EN to build the rollover pulse;
// otherwise rollover is tied to 0.

module stopwatch_core #(
    parameter int unsigned MAX_MIN = 59
) (
    input  logic       clk_100mhz,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause_btn,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       paused,
    output logic       blink_on,
    output logic       rollover
);

    localparam logic [3:0] MAX_MIN_TENS = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_MIN_ONES = 4'(MAX_MIN % 10);

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_PAUSE,
        MODE_ADJUST
    } mode_t;

    mode_t mode;

    logic       sec_at_max;
    logic       min_at_max;
    logic [3:0] sec_tens_inc;
    logic [3:0] sec_ones_inc;
    logic [3:0] min_tens_inc;
    logic [3:0] min_ones_inc;

    // Mode follows the live adj input, so an adj change applies on the same
    // edge as any tick; paused is the pre-toggle value.
    always_comb begin
        if (adj) begin
            mode = MODE_ADJUST;
        end else if (paused) begin
            mode = MODE_PAUSE;
        end else begin
            mode = MODE_RUN;
        end
    end

    // Wrapping BCD increments of each field; no carry between fields here,
    // the RUN branch chains them using sec_at_max.
    always_comb begin
        sec_at_max = (sec_tens == 4'd5) && (sec_ones == 4'd9);
        if (sec_ones == 4'd9) begin
            sec_ones_inc = '0;
            sec_tens_inc = sec_at_max ? '0 : sec_tens + 4'd1;
        end else begin
            sec_ones_inc = sec_ones + 4'd1;
            sec_tens_inc = sec_tens;
        end

        min_at_max = (min_tens == MAX_MIN_TENS) && (min_ones == MAX_MIN_ONES);
        if (min_at_max) begin
            min_ones_inc = '0;
            min_tens_inc = '0;
        end else if (min_ones == 4'd9) begin
            min_ones_inc = '0;
            min_tens_inc = min_tens + 4'd1;
        end else begin
            min_ones_inc = min_ones + 4'd1;
            min_tens_inc = min_tens;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            min_tens <= '0;
            min_ones <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
            paused   <= 1'b0;
            blink_on <= 1'b1;
        end else begin
            if (pause_btn) begin
                paused <= ~paused;
            end

            case (mode)
                MODE_ADJUST: begin
                    if (tick_2hz) begin
                        blink_on <= ~blink_on;
                        if (sel) begin
                            sec_tens <= sec_tens_inc;
                            sec_ones <= sec_ones_inc;
                        end else begin
                            min_tens <= min_tens_inc;
                            min_ones <= min_ones_inc;
                        end
                    end
                end
                MODE_RUN: begin
                    blink_on <= 1'b1;
                    if (tick_1hz) begin
                        sec_tens <= sec_tens_inc;
                        sec_ones <= sec_ones_inc;
                        if (sec_at_max) begin
                            min_tens <= min_tens_inc;
                            min_ones <= min_ones_inc;
                        end
                    end
                end
                default: begin
                    blink_on <= 1'b1;
                end
            endcase
        end
    end

`ifdef STOPWATCH_ROLLOVER_EN
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            rollover <= 1'b0;
        end else begin
            rollover <= (mode == MODE_RUN) && tick_1hz && sec_at_max && min_at_max;
        end
    end
`else
    assign rollover = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core -- self-checking bench for stopwatch_core.
// A time-in-seconds reference model is compared against the DUT on every
// negative clock edge; directed sequences add literal expectations, then a
// randomized phase exercises all input combinations.

module tb_stopwatch_core;

    localparam int MAX_MIN = 59;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       t1 = 1'b0;
    logic       t2 = 1'b0;
    logic       pb = 1'b0;
    logic       adj_i = 1'b0;
    logic       sel_i = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       paused, blink_on, rollover;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int cycle = 0;

    // Reference model state
    int m_min = 0;
    int m_sec = 0;
    bit m_pause = 1'b0;
    bit m_blink = 1'b1;
    bit m_roll = 1'b0;

`ifdef STOPWATCH_ROLLOVER_EN
    localparam bit ROLL_EN = 1'b1;
`else
    localparam bit ROLL_EN = 1'b0;
`endif

    stopwatch_core #(.MAX_MIN(MAX_MIN)) dut (
        .clk_100mhz(clk),
        .rst       (rst_i),
        .tick_1hz  (t1),
        .tick_2hz  (t2),
        .pause_btn (pb),
        .adj       (adj_i),
        .sel       (sel_i),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .paused    (paused),
        .blink_on  (blink_on),
        .rollover  (rollover)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Model: time kept as plain integers; RUN counts total seconds modulo
    // (MAX_MIN+1)*60, ADJUST bumps one field modulo its range.
    always @(posedge clk) begin : model
        int total;
        int nm;
        int ns;
        bit nb;
        bit nr;
        nm = m_min;
        ns = m_sec;
        nb = m_blink;
        nr = 1'b0;
        if (rst_i) begin
            m_min   <= 0;
            m_sec   <= 0;
            m_pause <= 1'b0;
            m_blink <= 1'b1;
            m_roll  <= 1'b0;
        end else begin
            if (adj_i) begin
                if (t2) begin
                    nb = !m_blink;
                    if (sel_i) ns = (m_sec + 1) % 60;
                    else       nm = (m_min + 1) % (MAX_MIN + 1);
                end
            end else begin
                nb = 1'b1;
                if (!m_pause && t1) begin
                    total = m_min * 60 + m_sec + 1;
                    if (total == (MAX_MIN + 1) * 60) begin
                        total = 0;
                        nr = ROLL_EN;
                    end
                    nm = total / 60;
                    ns = total % 60;
                end
            end
            m_min   <= nm;
            m_sec   <= ns;
            m_blink <= nb;
            m_roll  <= nr;
            if (pb) m_pause <= !m_pause;
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin : compare
        logic [18:0] act;
        logic [18:0] exp;
        if (chk_en) begin
            act = {min_tens, min_ones, sec_tens, sec_ones, paused, blink_on, rollover};
            exp = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
                   m_pause, m_blink, m_roll};
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL model_cmp cycle %0d: dut %0h%0h:%0h%0h p=%0b b=%0b r=%0b, want %0h%0h:%0h%0h p=%0b b=%0b r=%0b",
                         cycle, act[18:15], act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
                         exp[18:15], exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int dut_time();
        return int'(min_tens) * 1000 + int'(min_ones) * 100 + int'(sec_tens) * 10 + int'(sec_ones);
    endfunction

    // One clock cycle with the given pulses; returns at the following negedge.
    task automatic cyc(input bit r, input bit a, input bit b, input bit p);
        rst_i = r;
        t1    = a;
        t2    = b;
        pb    = p;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        t1    = 1'b0;
        t2    = 1'b0;
        pb    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick2(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        // Reset then count
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        chk("reset_time", dut_time(), 0);
        chk("reset_paused", int'(paused), 0);
        chk("reset_blink", int'(blink_on), 1);
        chk("reset_rollover", int'(rollover), 0);
        for (int i = 0; i < 61; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 0) chk("first_tick_latency", dut_time(), 1);
            idle(9);
        end
        chk("count_61", dut_time(), 101);
        chk("count_paused", int'(paused), 0);

        // Full wrap: preload 59:58 through ADJUST
        adj_i = 1'b1;
        sel_i = 1'b0;
        tick2(58);
        sel_i = 1'b1;
        tick2(57);
        chk("preload", dut_time(), 5958);
        adj_i = 1'b0;
        idle(1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap_5959", dut_time(), 5959);
        chk("wrap_no_roll_early", int'(rollover), 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap_0000", dut_time(), 0);
        chk("wrap_rollover", int'(rollover), int'(ROLL_EN));
        idle(1);
        chk("rollover_one_cycle", int'(rollover), 0);

        // Pause collision
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("run_0005", dut_time(), 5);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("pause_coll_time", dut_time(), 6);
        chk("pause_coll_flag", int'(paused), 1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("paused_hold", dut_time(), 6);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("resume_coll_time", dut_time(), 6);
        chk("resume_coll_flag", int'(paused), 0);

        // Adjust seconds from 00:58
        adj_i = 1'b1;
        sel_i = 1'b1;
        tick2(52);
        adj_i = 1'b0;
        idle(1);
        chk("preload_0058", dut_time(), 58);
        adj_i = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("adj_sec_1", dut_time(), 59);
        chk("adj_blink_1", int'(blink_on), 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("adj_ignores_1hz", dut_time(), 59);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("adj_sec_wrap", dut_time(), 0);
        chk("adj_blink_2", int'(blink_on), 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("adj_sec_3", dut_time(), 1);
        chk("adj_blink_3", int'(blink_on), 0);

        // Adjust minutes: 58:30 -> 59:30 -> 00:30
        tick2(29);
        sel_i = 1'b0;
        tick2(58);
        chk("preload_5830", dut_time(), 5830);
        tick2(1);
        chk("adj_min_59", dut_time(), 5930);
        tick2(1);
        chk("adj_min_wrap", dut_time(), 30);
        adj_i = 1'b0;
        idle(1);
        chk("exit_adj_blink", int'(blink_on), 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("exit_adj_count", dut_time(), 31);

        // Reset mid-adjust with pause set
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        adj_i = 1'b1;
        tick2(3);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("rst_adj_time", dut_time(), 0);
        chk("rst_adj_blink", int'(blink_on), 1);
        chk("rst_adj_paused", int'(paused), 0);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) adj_i = ~adj_i;
            if ($urandom_range(0, 9) == 0)  sel_i = ~sel_i;
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 19) == 0);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

- Consumes the single-cycle clock-enable ticks produced by the `clock` divider: `tick_1hz` for counting, `tick_2hz` for adjust and blink.
- Maintains a BCD mm:ss stopwatch with pause and per-field adjust.
- Emits four BCD digits plus a blink qualifier, which feed the 500 Hz seven-segment multiplexer.
- Sits between the clock divider, the button debouncers and the display driver in the Lab3 top level.

## Interface
- `MAX_MIN`, default 59: highest minutes value before wrap to 0; legal range 1..99.
- `clk_100mhz`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `tick_1hz`  in  1  count enable from the divider; every high cycle is one count event.
- `tick_2hz`  in  1  adjust/blink enable from the divider; every high cycle is one event.
- `pause_btn`  in  1  debounced single-cycle pulse; toggles pause.
- `adj`  in  1  level; 1 = adjust mode.
- `sel`  in  1  level; 0 = adjust minutes, 1 = adjust seconds.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  registered BCD digits.
- `paused`  out  1  registered pause flag.
- `blink_on`  out  1  registered; 0 = blank the digits of the selected field.
- `rollover`  out  1  registered one-cycle pulse on 59:59→00:00 (see Configuration).

## Operation
**Priority** (highest first): `rst`, then `adj`, then normal counting. All state updates on the `clk_100mhz` rising edge only.

**Reset** forces:
- all digits = 0
- `paused` = 0 (running)
- `blink_on` = 1
- `rollover` = 0

**Mode states**, derived from `adj` and `paused`:
- RUN: `adj`=0, `paused`=0.
- PAUSE: `adj`=0, `paused`=1.
- ADJUST: `adj`=1; independent of `paused`.

**Pause:**
- `pause_btn` toggles `paused` in every mode, including ADJUST.
- Leaving ADJUST returns to RUN or PAUSE according to the current `paused` value.

**RUN, on `tick_1hz`:**
- Seconds +1; at 59, seconds → 00 and minutes +1.
- Minutes at `MAX_MIN` with a carry → 00.
- `sec_ones` wraps 9→0 with carry into `sec_tens`; `sec_tens` wraps 5→0 with carry into minutes. Minutes BCD carry works the same way.

**PAUSE:** `tick_1hz` is ignored; digits hold.

**ADJUST, on `tick_2hz`:**
- Increments the field chosen by `sel`.
- Seconds wrap 59→00; minutes wrap `MAX_MIN`→00.
- No carry between fields.
- `tick_1hz` is ignored.

**`blink_on`:**
- In ADJUST, toggles on each `tick_2hz`.
- While `adj`=0, `blink_on` = 1 (loaded on every edge).
- On entry to ADJUST, starts from 1.

**Digit legality:** digits never hold non-BCD values. Each tens digit is ≤5, except minutes tens, which is ≤ `MAX_MIN`/10.

## Timing
- Every output changes on the edge where its cause is sampled. Visible one cycle after a tick is asserted; latency 1.
- **`pause_btn` and `tick_1hz` in the same cycle:** the count decision uses the pre-toggle `paused` value.
  - RUN + both → count, then pause.
  - PAUSE + both → no count, then resume.
- **`adj` changes on the same cycle as a tick:** the new `adj` value governs that cycle.
- **`sel` changes on the same cycle as `tick_2hz`:** the new `sel` selects the field.
- **`rst` on the same cycle as any tick:** reset wins and the tick is lost.
- **Reset mid-operation** has the same effect as reset at power-up.
- **Ticks held high N cycles** produce N events. The divider guarantees 1-cycle pulses, but the block does not rely on it.

## Configuration
- `STOPWATCH_ROLLOVER_EN` defined:
  - `rollover` pulses high for exactly one cycle, on the edge where RUN wraps `MAX_MIN`:59 → 00:00.
  - Adjust-mode wraps do not pulse.
- Not defined: `rollover` is tied to constant 0 and no rollover logic is built.

## Test plan
- **Reset then count:** `rst` 2 cycles, then 61 `tick_1hz` pulses 10 cycles apart → digits 01:01, `paused`=0, each change one cycle after its tick.
- **Full wrap:** preload to 59:58 via ADJUST, return to RUN, give 2 ticks → 59:59, then 00:00. With `STOPWATCH_ROLLOVER_EN`, `rollover`=1 for exactly one cycle; without it, `rollover` stays 0.
- **Pause collision:**
  - In RUN at 00:05, pulse `pause_btn` and `tick_1hz` together → 00:06, `paused`=1.
  - 3 more ticks → still 00:06.
  - `pause_btn` + tick together → 00:06, `paused`=0.
- **Adjust seconds:** `adj`=1, `sel`=1 from 00:58, 3 `tick_2hz` → 00:59, 00:00, 00:01 with minutes unchanged. `blink_on` goes 1→0→1→0; `tick_1hz` pulses are ignored.
- **Adjust minutes with `MAX_MIN`=59:** from 58:30, `sel`=0, 2 `tick_2hz` → 59:30 then 00:30. Drop `adj` → `blink_on`=1 on the next edge and counting resumes.
- **Reset mid-adjust:** `adj`=1, `rst` asserted together with `tick_2hz` → 00:00, `blink_on`=1, `paused`=0.
